// File: rtl/conv_timing_controller.sv
// ----------------------------------------------------------------------------
// conv_timing_controller
//
// Sequences one ADC frame: for each channel 0..NUM_CHANNELS-1 it pulses
// CONVST, waits for an external conversion timer to reach terminal count,
// strobes the parallel read bus, registers the sample and flags it valid.
// The external timer is driven through count_sel (ZERO / HOLD / COUNT).
//
// State table
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | no frame in progress, waiting for start
//   CONVST    | one-cycle conversion-start pulse, timer held at zero
//   WAIT_CONV | timer counting (or held by pause) until count_reached
//   READ      | one-cycle read strobe, sample captured on the closing edge
//   NEXT      | sample_valid pulse; advance channel or finish the frame
//
// Ports
//   clk, reset_b   clock, asynchronous active-low reset
//   start          frame request (sampled only in IDLE)
//   abort          terminate any frame in progress
//   pause          freeze the conversion timer in WAIT_CONV
//   count_reached  terminal-count flag from the external timer
//   adc_data       ADC parallel read bus
//   count_sel      timer command: ZERO=00, HOLD=10, COUNT=11
//   adc_convst     conversion-start pulse, active-high
//   adc_rd_n       read strobe, active-low
//   adc_ch         channel currently being converted
//   sample_data    last captured sample
//   sample_ch      channel index of sample_data
//   sample_valid   one-cycle pulse when sample_data/sample_ch are new
//   busy           high in every state except IDLE
//   frame_done     one-cycle pulse alongside the last channel's sample_valid
// ----------------------------------------------------------------------------
module conv_timing_controller #(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_BIT_WIDTH = 2,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    pause,
    input  logic                    count_reached,
    input  logic [DATA_WIDTH-1:0]   adc_data,
    output logic [1:0]              count_sel,
    output logic                    adc_convst,
    output logic                    adc_rd_n,
    output logic [CH_BIT_WIDTH-1:0] adc_ch,
    output logic [DATA_WIDTH-1:0]   sample_data,
    output logic [CH_BIT_WIDTH-1:0] sample_ch,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [1:0] CS_ZERO  = 2'b00;
    localparam logic [1:0] CS_HOLD  = 2'b10;
    localparam logic [1:0] CS_COUNT = 2'b11;

    localparam logic [CH_BIT_WIDTH-1:0] LAST_CH = CH_BIT_WIDTH'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONVST    = 3'd1,
        S_WAIT_CONV = 3'd2,
        S_READ      = 3'd3,
        S_NEXT      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CH_BIT_WIDTH-1:0] adc_ch_q, adc_ch_d;
    logic [DATA_WIDTH-1:0]   sample_data_q, sample_data_d;
    logic [CH_BIT_WIDTH-1:0] sample_ch_q, sample_ch_d;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= S_IDLE;
            adc_ch_q      <= '0;
            sample_data_q <= '0;
            sample_ch_q   <= '0;
        end else begin
            state_q       <= state_d;
            adc_ch_q      <= adc_ch_d;
            sample_data_q <= sample_data_d;
            sample_ch_q   <= sample_ch_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        adc_ch_d      = adc_ch_q;
        sample_data_d = sample_data_q;
        sample_ch_d   = sample_ch_q;
        count_sel     = CS_ZERO;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_CONVST;
                    adc_ch_d = '0;
                end
            end
            S_CONVST: begin
                state_d = S_WAIT_CONV;
            end
            S_WAIT_CONV: begin
                // Completion takes priority over pause so the timer is
                // zeroed in the same cycle the wait ends.
                if (count_reached) begin
                    count_sel = CS_ZERO;
                    state_d   = S_READ;
                end else if (pause) begin
                    count_sel = CS_HOLD;
                end else begin
                    count_sel = CS_COUNT;
                end
            end
            S_READ: begin
                state_d = S_NEXT;
                if (!abort) begin
                    sample_data_d = adc_data;
                    sample_ch_d   = adc_ch_q;
                end
            end
            S_NEXT: begin
                if (adc_ch_q == LAST_CH) begin
                    state_d  = S_IDLE;
                    adc_ch_d = '0;
                end else begin
                    state_d  = S_CONVST;
                    adc_ch_d = adc_ch_q + CH_BIT_WIDTH'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                adc_ch_d = '0;
            end
        endcase

        // Abort overrides every transition; the captured sample is kept.
        if (abort) begin
            state_d  = S_IDLE;
            adc_ch_d = '0;
        end
    end

    assign adc_convst   = (state_q == S_CONVST);
    assign adc_rd_n     = (state_q != S_READ);
    assign adc_ch       = adc_ch_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = (state_q == S_NEXT);
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = (state_q == S_NEXT) && (adc_ch_q == LAST_CH);

endmodule

// File: tb/tb_conv_timing_controller.sv
// ----------------------------------------------------------------------------
// tb_conv_timing_controller
//
// Pairs the controller with a behavioural conversion timer (terminal value 3)
// and checks frame timing, pause, abort, start filtering, spurious
// count_reached and asynchronous reset. Cycle index n=1 is the first cycle
// after the edge that samples start (the CONVST cycle of channel 0).
// ----------------------------------------------------------------------------
module tb_conv_timing_controller;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int DW  = 16;

    logic           clk = 1'b0;
    logic           reset_b = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           pause = 1'b0;
    logic           count_reached;
    logic [DW-1:0]  adc_data;
    logic [1:0]     count_sel;
    logic           adc_convst;
    logic           adc_rd_n;
    logic [CHW-1:0] adc_ch;
    logic [DW-1:0]  sample_data;
    logic [CHW-1:0] sample_ch;
    logic           sample_valid;
    logic           busy;
    logic           frame_done;

    logic [3:0]     tcnt;
    logic           cr_force = 1'b0;

    int checks = 0;
    int errors = 0;

    int sv_n[$];
    int sv_d[$];
    int sv_c[$];
    int fd_n[$];
    int busy_cnt;
    int hold_cnt;
    int bad01_cnt;
    int convst_cnt;
    int rdlow_cnt;

    conv_timing_controller #(
        .NUM_CHANNELS (NCH),
        .CH_BIT_WIDTH (CHW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .start         (start),
        .abort         (abort),
        .pause         (pause),
        .count_reached (count_reached),
        .adc_data      (adc_data),
        .count_sel     (count_sel),
        .adc_convst    (adc_convst),
        .adc_rd_n      (adc_rd_n),
        .adc_ch        (adc_ch),
        .sample_data   (sample_data),
        .sample_ch     (sample_ch),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural conversion timer, terminal value 3.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)                tcnt <= '0;
        else if (count_sel == 2'b00) tcnt <= '0;
        else if (count_sel == 2'b11) tcnt <= tcnt + 4'd1;
    end

    assign count_reached = (tcnt == 4'd3) | cr_force;
    assign adc_data      = 16'hA000 + 16'(adc_ch);

    // Steps ncyc cycles from just after a rising edge, applying stimulus per
    // cycle index and recording observed events at each falling edge.
    task automatic run(input bit go, input int ncyc, input int s_a, input int s_b,
                       input int a_at, input int p0, input int p1,
                       input int cr_a, input int cr_b, input int cr_c);
        sv_n.delete(); sv_d.delete(); sv_c.delete(); fd_n.delete();
        busy_cnt = 0; hold_cnt = 0; bad01_cnt = 0; convst_cnt = 0; rdlow_cnt = 0;
        for (int n = 0; n <= ncyc; n++) begin
            start    = (go && n == 0) || n == s_a || n == s_b;
            abort    = (n == a_at);
            pause    = (n >= p0) && (n < p1);
            cr_force = (n == cr_a) || (n == cr_b) || (n == cr_c);
            @(negedge clk);
            if (n >= 1) begin
                if (busy)                busy_cnt++;
                if (count_sel == 2'b10)  hold_cnt++;
                if (count_sel == 2'b01)  bad01_cnt++;
                if (adc_convst)          convst_cnt++;
                if (!adc_rd_n)           rdlow_cnt++;
                if (sample_valid) begin
                    sv_n.push_back(n);
                    sv_d.push_back(int'(sample_data));
                    sv_c.push_back(int'(sample_ch));
                end
                if (frame_done) fd_n.push_back(n);
            end
            @(posedge clk);
            #1;
        end
        start = 0; abort = 0; pause = 0; cr_force = 0;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (count_sel !== 2'b00) begin errors++; $display("FAIL rst_count_sel got %b exp 00", count_sel); end
        checks++; if (adc_convst !== 1'b0) begin errors++; $display("FAIL rst_convst got %b exp 0", adc_convst); end
        checks++; if (adc_rd_n !== 1'b1) begin errors++; $display("FAIL rst_rd_n got %b exp 1", adc_rd_n); end
        checks++; if (adc_ch !== 2'd0) begin errors++; $display("FAIL rst_adc_ch got %0d exp 0", adc_ch); end
        checks++; if (sample_data !== 16'h0000) begin errors++; $display("FAIL rst_sample_data got %h exp 0000", sample_data); end
        checks++; if (sample_ch !== 2'd0) begin errors++; $display("FAIL rst_sample_ch got %0d exp 0", sample_ch); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_sample_valid got %b exp 0", sample_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
        reset_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal();
        run(1, 35, -1, -1, -1, -1, -1, -1, -1, -1);
        checks++; if (sv_n.size() != 4) begin errors++; $display("FAIL nom_valid_count got %0d exp 4", sv_n.size()); end
        for (int k = 0; k < 4 && k < sv_n.size(); k++) begin
            checks++; if (sv_n[k] != 7 * (k + 1)) begin errors++; $display("FAIL nom_valid_cycle[%0d] got %0d exp %0d", k, sv_n[k], 7 * (k + 1)); end
            checks++; if (sv_d[k] != 32'hA000 + k) begin errors++; $display("FAIL nom_data[%0d] got %h exp %h", k, sv_d[k], 32'hA000 + k); end
            checks++; if (sv_c[k] != k) begin errors++; $display("FAIL nom_ch[%0d] got %0d exp %0d", k, sv_c[k], k); end
        end
        checks++; if (fd_n.size() != 1 || fd_n[0] != 28) begin errors++; $display("FAIL nom_frame_done got count %0d exp one at 28", fd_n.size()); end
        checks++; if (busy_cnt != 28) begin errors++; $display("FAIL nom_busy_cycles got %0d exp 28", busy_cnt); end
        checks++; if (convst_cnt != 4) begin errors++; $display("FAIL nom_convst got %0d exp 4", convst_cnt); end
        checks++; if (rdlow_cnt != 4) begin errors++; $display("FAIL nom_rd_n_low got %0d exp 4", rdlow_cnt); end
        checks++; if (bad01_cnt != 0) begin errors++; $display("FAIL nom_count_sel_01 got %0d exp 0", bad01_cnt); end
    endtask

    task automatic test_pause();
        // ch1 WAIT_CONV spans n=9..12; pause n=10..14 holds the timer at 1.
        run(1, 40, -1, -1, -1, 10, 15, -1, -1, -1);
        checks++; if (hold_cnt != 5) begin errors++; $display("FAIL pause_hold_cycles got %0d exp 5", hold_cnt); end
        checks++; if (bad01_cnt != 0) begin errors++; $display("FAIL pause_count_sel_01 got %0d exp 0", bad01_cnt); end
        checks++; if (sv_n.size() != 4) begin errors++; $display("FAIL pause_valid_count got %0d exp 4", sv_n.size()); end
        else begin
            checks++; if (sv_n[0] != 7) begin errors++; $display("FAIL pause_ch0_cycle got %0d exp 7", sv_n[0]); end
            checks++; if (sv_n[1] != 19) begin errors++; $display("FAIL pause_ch1_cycle got %0d exp 19", sv_n[1]); end
            checks++; if (sv_n[3] != 33) begin errors++; $display("FAIL pause_ch3_cycle got %0d exp 33", sv_n[3]); end
            checks++; if (sv_d[1] != 32'hA001) begin errors++; $display("FAIL pause_ch1_data got %h exp a001", sv_d[1]); end
        end
        checks++; if (fd_n.size() != 1 || fd_n[0] != 33) begin errors++; $display("FAIL pause_frame_done got count %0d exp one at 33", fd_n.size()); end
    endtask

    task automatic test_abort();
        // ch2 READ is n=20.
        run(1, 35, -1, -1, 20, -1, -1, -1, -1, -1);
        checks++; if (busy_cnt != 20) begin errors++; $display("FAIL abort_busy_cycles got %0d exp 20", busy_cnt); end
        checks++; if (sv_n.size() != 2) begin errors++; $display("FAIL abort_valid_count got %0d exp 2", sv_n.size()); end
        checks++; if (fd_n.size() != 0) begin errors++; $display("FAIL abort_frame_done got %0d exp 0", fd_n.size()); end
        checks++; if (sample_data !== 16'hA001) begin errors++; $display("FAIL abort_sample_data got %h exp a001", sample_data); end
        checks++; if (sample_ch !== 2'd1) begin errors++; $display("FAIL abort_sample_ch got %0d exp 1", sample_ch); end
        checks++; if (adc_ch !== 2'd0) begin errors++; $display("FAIL abort_adc_ch got %0d exp 0", adc_ch); end
    endtask

    task automatic test_start_filter();
        run(1, 35, 10, 20, -1, -1, -1, -1, -1, -1);
        checks++; if (busy_cnt != 28) begin errors++; $display("FAIL restart_busy_cycles got %0d exp 28", busy_cnt); end
        checks++; if (sv_n.size() != 4 || sv_n[3] != 28) begin errors++; $display("FAIL restart_valid got count %0d exp 4 ending at 28", sv_n.size()); end
        checks++; if (convst_cnt != 4) begin errors++; $display("FAIL restart_convst got %0d exp 4", convst_cnt); end
        run(0, 5, 1, -1, 1, -1, -1, -1, -1, -1);
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL start_abort_busy got %0d exp 0", busy_cnt); end
        checks++; if (convst_cnt != 0) begin errors++; $display("FAIL start_abort_convst got %0d exp 0", convst_cnt); end
    endtask

    task automatic test_spurious_cr();
        run(0, 5, -1, -1, -1, -1, -1, 1, 2, 3);
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL spur_idle_busy got %0d exp 0", busy_cnt); end
        // n=1 CONVST ch0, n=6 READ ch0, n=13 READ ch1.
        run(1, 35, -1, -1, -1, -1, -1, 1, 6, 13);
        checks++; if (busy_cnt != 28) begin errors++; $display("FAIL spur_busy_cycles got %0d exp 28", busy_cnt); end
        checks++; if (sv_n.size() != 4) begin errors++; $display("FAIL spur_valid_count got %0d exp 4", sv_n.size()); end
        else begin
            checks++; if (sv_n[0] != 7 || sv_n[1] != 14 || sv_n[2] != 21) begin errors++; $display("FAIL spur_valid_cycles got %0d %0d %0d exp 7 14 21", sv_n[0], sv_n[1], sv_n[2]); end
        end
    endtask

    task automatic test_async_reset();
        run(1, 10, -1, -1, -1, -1, -1, -1, -1, -1);
        // Now in ch1 WAIT_CONV with sample_data=A000; reset between edges.
        #2;
        reset_b = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
        checks++; if (count_sel !== 2'b00) begin errors++; $display("FAIL areset_count_sel got %b exp 00", count_sel); end
        checks++; if (sample_data !== 16'h0000) begin errors++; $display("FAIL areset_sample_data got %h exp 0000", sample_data); end
        checks++; if (adc_ch !== 2'd0 || adc_rd_n !== 1'b1 || adc_convst !== 1'b0) begin errors++; $display("FAIL areset_adc got ch %0d rd_n %b convst %b exp 0 1 0", adc_ch, adc_rd_n, adc_convst); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL areset_pulses got sv %b fd %b exp 0 0", sample_valid, frame_done); end
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        run(1, 35, -1, -1, -1, -1, -1, -1, -1, -1);
        checks++; if (sv_n.size() != 4 || sv_n[0] != 7 || sv_n[3] != 28) begin errors++; $display("FAIL areset_refrm_valid got count %0d exp 4 at 7..28", sv_n.size()); end
        checks++; if (busy_cnt != 28) begin errors++; $display("FAIL areset_refrm_busy got %0d exp 28", busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_pause();
        test_abort();
        test_start_filter();
        test_spurious_cr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
